// File: rtl/mha_seq_multiplier.sv
// mha_seq_multiplier: iterative array multiplier built from rows of modified
// half-adder cells. ROWS partial-product rows (multiplicand ANDed with one
// multiplier bit, shifted to that bit's weight) are summed into a 2*WIDTH
// accumulator per clock, so a WIDTH x WIDTH product takes WIDTH/ROWS cycles.
// Valid/ready handshakes on both the operand and the result side.
//
// Optional feature: define MHA_MULT_SIGNED_EN to add the signed_mode port.
// When set at acceptance, the multiplicand is sign-extended and the row for
// the multiplier sign bit is subtracted, giving the two's-complement product.
// Without the macro the block is unsigned only.
module mha_seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
`ifdef MHA_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int K  = WIDTH / ROWS;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(K - 1);
    localparam logic [IW-1:0] SIGN_ROW  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    product_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Effective signedness of the operation in flight.
    logic             sm_eff;

    // Combinational helpers for the row adders.
    logic [PW-1:0]    x_ext;
    logic [PW-1:0]    row_pp;
    logic [IW-1:0]    row_idx;

`ifdef MHA_MULT_SIGNED_EN
    logic sm_q;
    assign sm_eff = sm_q;
`else
    assign sm_eff = 1'b0;
`endif

    // Add (or, for the signed sign-bit row, subtract) the ROWS rows selected by cnt_q.
    always_comb begin
        // NOTE: every variable gets an unconditional default first, so no latch is inferred.
        x_ext   = sm_eff ? {{WIDTH{x_q[WIDTH-1]}}, x_q} : {{WIDTH{1'b0}}, x_q};
        acc_d   = acc_q;
        row_idx = '0;
        row_pp  = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_idx = IW'(int'(cnt_q) * ROWS + r);
            row_pp  = (x_ext & {PW{y_q[row_idx]}}) << row_idx;
            if (sm_eff && (row_idx == SIGN_ROW)) begin
                acc_d = acc_d - row_pp;
            end else begin
                acc_d = acc_d + row_pp;
            end
        end
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
`ifdef MHA_MULT_SIGNED_EN
            sm_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= x;
                        y_q        <= y;
`ifdef MHA_MULT_SIGNED_EN
                        sm_q       <= signed_mode;
`endif
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
